// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if: valid/ready handshake bundle for the elastic pipeline register.
// Revision: 1.0
`default_nettype none

interface pipe_skid_reg_if #(
    parameter int DATA_W = 36,
    parameter int CTRL_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );
endinterface

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: 2-entry skid pipeline register with flush, bubble masking and stall counter.
// Revision: 1.0
`default_nettype none

module pipe_skid_reg #(
    parameter int DATA_W         = 36,
    parameter int CTRL_W         = 2,
    parameter int CNT_W          = 16,
    parameter int CLEAR_ON_FLUSH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             flush,
    pipe_skid_reg_if.slave        bus,
    output logic [1:0]            occupancy,
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic               w_ld_main_in;
    logic               w_ld_main_skid;
    logic               w_ld_skid;
    logic               w_out_valid;
    logic [DATA_W-1:0]  r_main_data;
    logic [CTRL_W-1:0]  r_main_ctrl;
    logic [DATA_W-1:0]  r_skid_data;
    logic [CTRL_W-1:0]  r_skid_ctrl;
    logic [CNT_W-1:0]   r_stall_cnt;

    // Handshake flags are pure decodes of the state register, so no
    // combinational path exists from out_ready to in_ready.
    assign w_out_valid   = (r_state != ST_EMPTY);
    assign bus.out_valid = w_out_valid;
    assign bus.in_ready  = (r_state != ST_FULL);
    assign bus.out_data  = r_main_data;
    assign bus.out_ctrl  = r_main_ctrl & {CTRL_W{w_out_valid}};
    assign occupancy     = r_state;
    assign stall_cnt     = r_stall_cnt;

    always_comb begin
        w_state_nx     = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (bus.in_valid) begin
                    w_ld_main_in = 1'b1;
                    w_state_nx   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (bus.in_valid && bus.out_ready) begin
                    w_ld_main_in = 1'b1;
                end else if (bus.in_valid) begin
                    w_ld_skid  = 1'b1;
                    w_state_nx = ST_FULL;
                end else if (bus.out_ready) begin
                    w_state_nx = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (bus.out_ready) begin
                    w_ld_main_skid = 1'b1;
                    w_state_nx     = ST_ONE;
                end
            end
            default: w_state_nx = ST_EMPTY;
        endcase
        if (flush) begin
            w_state_nx = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (flush) begin
            if (CLEAR_ON_FLUSH != 0) begin
                r_main_data <= '0;
                r_main_ctrl <= '0;
                r_skid_data <= '0;
                r_skid_ctrl <= '0;
            end
        end else begin
            if (w_ld_main_in) begin
                r_main_data <= bus.in_data;
                r_main_ctrl <= bus.in_ctrl;
            end else if (w_ld_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_ld_skid) begin
                r_skid_data <= bus.in_data;
                r_skid_ctrl <= bus.in_ctrl;
            end
        end
    end

    // Counts stalls in the flush cycle too; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !bus.out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised elastic pipeline register, the successor to the fixed-field stage registers (EX/MEM, MEM/WB) of the ARM pipeline. It carries a generic data bundle and a separately masked control bundle (WB_en, MEM_r_en, ...) over a valid/ready handshake. A 2-entry skid buffer gives full throughput with a registered in_ready. The block adds synchronous flush, bubble masking of control bits, occupancy reporting and a saturating stall counter.

Parameters:
DATA_W, 36, width of the data bundle (e.g. {dest[3:0], alu_res[31:0]}); must be >= 1
CTRL_W, 2, width of the control bundle; forced to 0 on bubbles; must be >= 1
CNT_W, 16, width of the stall counter
CLEAR_ON_FLUSH, 1, 1: flush zeroes the data registers; 0: flush leaves data registers unchanged

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous flush; discards all held entries
in_valid  in  1  upstream bundle valid
in_ready  out  1  block can accept; registered
in_data  in  DATA_W  upstream data bundle
in_ctrl  in  CTRL_W  upstream control bundle
out_valid  out  1  head entry valid; registered
out_ready  in  1  downstream accepts head entry
out_data  out  DATA_W  head entry data
out_ctrl  out  CTRL_W  head entry control; 0 when out_valid=0
occupancy  out  2  entries held: 0, 1 or 2
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating

Behaviour:
- Reset (asynchronous): state EMPTY, in_ready=1, out_valid=0, out_data=0, out_ctrl=0, skid registers=0, occupancy=0, stall_cnt=0.
- Storage: a main register drives out_*; a skid register holds the second entry. in_acc = in_valid & in_ready. out_acc = out_valid & out_ready.
- States:
  - EMPTY (occ 0): on in_acc, main <= input, go to ONE.
  - ONE (occ 1):
    - in_acc & out_acc: main <= input, stay in ONE.
    - in_acc & !out_ready: skid <= input, go to FULL.
    - !in_valid & out_ready: go to EMPTY.
    - neither: hold.
  - FULL (occ 2): in_ready=0, so in_valid is ignored. On out_ready, main <= skid and go to ONE.
- in_ready is 1 in EMPTY and ONE and 0 in FULL. It is a registered state decode: no combinational path from out_ready to in_ready.
- Latency: an entry accepted in cycle N appears on out_* in cycle N+1. Throughput is 1 entry/cycle while out_ready=1.
- Ordering: strict FIFO. The skid entry is never presented before the main entry.
- Bubble masking: out_ctrl = main_ctrl & {CTRL_W{out_valid}}. A bubble never asserts a write-enable downstream.
- flush (synchronous, priority below rst, above all other actions):
  - Next state is EMPTY; out_valid=0 and occupancy=0 on the next cycle.
  - An input accepted in the flush cycle is discarded.
  - An output handshake in the flush cycle counts as completed downstream.
  - If CLEAR_ON_FLUSH=1, main and skid data/ctrl are zeroed; otherwise only the valid bits are cleared.
  - in_ready=1 on the next cycle.
- stall_cnt: increments every cycle with out_valid & !out_ready, including the flush cycle. It saturates at 2^CNT_W-1 and is cleared only by rst.
- Data and ctrl registers load only on accept. No X is propagated from the inputs when in_valid=0.
- Reset asserted mid-transfer: all entries are lost and the outputs are zero immediately (asynchronous). The first accept is possible on the first rising edge after rst deasserts.

Test Plan:
- Streaming: out_ready=1; send data 0x1..0x8 (ctrl=2'b11) back-to-back -> out_valid from cycle 1, data 0x1..0x8 in order one per cycle, occupancy<=1, stall_cnt=0.
- Backpressure: with 0xA held, drop out_ready and present 0xB -> occupancy=2, in_ready=0 next cycle, 0xC held off. Raise out_ready -> 0xA, 0xB, 0xC delivered in order; stall_cnt equals the number of stalled cycles.
- Flush when FULL (0xA, 0xB held), out_ready=0, in_valid=1 with 0xC -> next cycle out_valid=0, occupancy=0, out_ctrl=0, out_data=0 (CLEAR_ON_FLUSH=1); 0xC never emerges.
- Bubble masking: in_ctrl=2'b11 on one entry, then in_valid=0 -> out_ctrl returns to 0 the cycle after consumption while out_data holds its last value.
- Reset mid-stream while FULL -> all outputs 0 asynchronously, in_ready=1 after release, the next entry is delivered with 1-cycle latency.
- Saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.
